// File: rtl/serial_addsub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl_pkg
// Shared definitions for the bit-serial add/subtract sequencer:
//   - state_e  : FSM state encoding (IDLE / RUN / DONE, 2-bit)
//   - OP_ADD / OP_SUB : operation select values for the SUB input
//   - signed_ovf() : overflow rule shared with the combinational ALU
// No ports (package).
// -----------------------------------------------------------------------------
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow: the carry into the MSB disagrees with the carry out of it.
    function automatic logic signed_ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl_if
// Requester-side bus of the serial add/subtract sequencer.
//   start  : request, sampled only when the sequencer is idle or done
//   sub    : 0 = A+B, 1 = A-B (sampled with start)
//   a, b   : WIDTH-bit operands (sampled with start)
//   busy   : operation in progress
//   done   : one-cycle completion pulse
//   result : WIDTH-bit sum/difference, held until the next completion
//   cout   : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : signed overflow
// Modports: master (requester) and slave (sequencer).
// -----------------------------------------------------------------------------
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );

endinterface

// File: rtl/serial_fa_bit.sv
// -----------------------------------------------------------------------------
// serial_fa_bit
// Combinational 1-bit full adder; the single arithmetic slice that the
// serial sequencer streams its operands through.
//   a_i, b_i : operand bits
//   cin_i    : carry in
//   s_o      : sum bit
//   cout_o   : carry out
// -----------------------------------------------------------------------------
module serial_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
// Sequencer for a bit-serial two's-complement add/subtract datapath. Operands
// are streamed LSB-first through one full-adder slice, one bit per clock, with
// the carry held in a flip-flop. Subtraction is A + ~B + 1: B is inverted at
// load time and the carry flip-flop is preset to 1.
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset; aborts any operation in flight
//   bus   : requester handshake (slave side), see serial_addsub_ctrl_if
// Timing: the START-sampling edge is edge 0; edges 1..WIDTH process bits
// 0..WIDTH-1; RESULT/COUT/OVF and the DONE pulse appear after edge WIDTH.
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_addsub_ctrl_if.slave  bus
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-1:0]   sr_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;

    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   sr_d;

    serial_fa_bit u_fa (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .cin_i  (carry_q),
        .s_o    (fa_s),
        .cout_o (fa_cout)
    );

    // Result shift register: the new sum bit enters at the MSB, so after
    // WIDTH shifts bit 0 of the result has reached bit 0.
    assign sr_d = WIDTH'({fa_s, sr_q} >> 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
                        sr_q    <= '0;
                        carry_q <= (bus.sub == OP_SUB);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    sr_q    <= sr_d;
                    carry_q <= fa_cout;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the MSB on this last bit.
                        cnt_q    <= '0;
                        result_q <= sr_d;
                        cout_q   <= fa_cout;
                        ovf_q    <= signed_ovf(carry_q, fa_cout);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_ctrl
// Directed and randomized bench for serial_addsub_ctrl at WIDTH=8, plus an
// exhaustive WIDTH=3 instance. Expected values come from an arithmetic model
// (modular sum, carry bit, sign-rule overflow).
// -----------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl_if #(.WIDTH(8)) b8 ();
    serial_addsub_ctrl_if #(.WIDTH(3)) b3 ();

    serial_addsub_ctrl #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(b8));
    serial_addsub_ctrl #(.WIDTH(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: modular arithmetic and the sign rule for overflow.
    function automatic void model(input int w, input int s, input int a, input int b,
                                  output int r, output int c, output int o);
        int mask, sum, am, bm, rm;
        mask = (1 << w) - 1;
        sum  = s ? (a - b + (1 << w)) : (a + b);
        r    = sum & mask;
        c    = (sum >> w) & 1;
        am   = (a >> (w - 1)) & 1;
        bm   = (b >> (w - 1)) & 1;
        rm   = (r >> (w - 1)) & 1;
        o    = s ? int'(am != bm && rm != am) : int'(am == bm && rm != am);
    endfunction

    // Issue one op on the 8-bit DUT; returns at #1 after the DONE edge.
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bz);
        @(negedge clk);
        b8.start = 1'b1; b8.sub = s; b8.a = a; b8.b = b;
        @(posedge clk); #1;
        b8.start = 1'b0;
        lat = 0; bz = 0;
        while (!b8.done && lat < 40) begin
            if (b8.busy) bz++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run3(input logic s, input logic [2:0] a, input logic [2:0] b, output int lat);
        @(negedge clk);
        b3.start = 1'b1; b3.sub = s; b3.a = a; b3.b = b;
        @(posedge clk); #1;
        b3.start = 1'b0;
        lat = 0;
        while (!b3.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bz, dcount, r, c, o;
        logic [7:0] rcap, ra, rb;
        logic rs;
        logic held_ok;

        b8.start = 0; b8.sub = 0; b8.a = '0; b8.b = '0;
        b3.start = 0; b3.sub = 0; b3.a = '0; b3.b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(b8.busy),   32'd0);
        chk("rst_done",   32'(b8.done),   32'd0);
        chk("rst_result", 32'(b8.result), 32'd0);
        chk("rst_cout",   32'(b8.cout),   32'd0);
        chk("rst_ovf",    32'(b8.ovf),    32'd0);
        @(negedge clk); rst = 1'b0;

        // 1: ADD 0x7F+0x01
        run8(1'b0, 8'h7F, 8'h01, lat, bz);
        chk("t1_latency", lat, 8);
        chk("t1_busy_cycles", bz, 8);
        chk("t1_busy_at_done", 32'(b8.busy), 32'd0);
        chk("t1_result", 32'(b8.result), 32'h80);
        chk("t1_cout", 32'(b8.cout), 32'd0);
        chk("t1_ovf", 32'(b8.ovf), 32'd1);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", 32'(b8.done), 32'd0);

        // 2: SUB 0x80-0x01 and 0x05-0x07
        run8(1'b1, 8'h80, 8'h01, lat, bz);
        chk("t2a_latency", lat, 8);
        chk("t2a_result", 32'(b8.result), 32'h7F);
        chk("t2a_cout", 32'(b8.cout), 32'd1);
        chk("t2a_ovf", 32'(b8.ovf), 32'd1);
        run8(1'b1, 8'h05, 8'h07, lat, bz);
        chk("t2b_result", 32'(b8.result), 32'hFE);
        chk("t2b_cout", 32'(b8.cout), 32'd0);
        chk("t2b_ovf", 32'(b8.ovf), 32'd0);

        // 3: ADD 0xFF+0x01, then RESULT holds through 20 idle cycles
        run8(1'b0, 8'hFF, 8'h01, lat, bz);
        chk("t3_result", 32'(b8.result), 32'h00);
        chk("t3_cout", 32'(b8.cout), 32'd1);
        chk("t3_ovf", 32'(b8.ovf), 32'd0);
        held_ok = 1'b1;
        b8.a = 8'hAA; b8.b = 8'h55;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (b8.result !== 8'h00 || b8.done !== 1'b0 || b8.busy !== 1'b0) held_ok = 1'b0;
        end
        chk("t3_hold_idle", 32'(held_ok), 32'd1);

        // 4: START pulsed during RUN is ignored
        @(negedge clk);
        b8.start = 1'b1; b8.sub = 1'b0; b8.a = 8'h10; b8.b = 8'h20;
        @(posedge clk); #1;
        b8.start = 1'b0;
        dcount = 0; rcap = '0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) begin
                @(negedge clk);
                b8.start = 1'b1; b8.a = 8'h01; b8.b = 8'h01;
            end
            @(posedge clk); #1;
            b8.start = 1'b0;
            if (b8.done) begin
                dcount++;
                rcap = b8.result;
            end
        end
        chk("t4_done_count", dcount, 1);
        chk("t4_result", 32'(rcap), 32'h30);

        // 4b: reset during the 4th RUN cycle aborts
        @(negedge clk);
        b8.start = 1'b1; b8.sub = 1'b0; b8.a = 8'h11; b8.b = 8'h22;
        @(posedge clk); #1;
        b8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_rst_busy", 32'(b8.busy), 32'd0);
        chk("t4_rst_done", 32'(b8.done), 32'd0);
        chk("t4_rst_result", 32'(b8.result), 32'd0);
        chk("t4_rst_cout", 32'(b8.cout), 32'd0);
        chk("t4_rst_ovf", 32'(b8.ovf), 32'd0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (b8.done || b8.busy) dcount++;
        end
        chk("t4_no_activity_after_rst", dcount, 0);

        // 5: START held high through the DONE cycle -> back-to-back ops
        @(negedge clk);
        b8.start = 1'b1; b8.sub = 1'b1; b8.a = 8'h03; b8.b = 8'h01;
        @(posedge clk); #1;
        b8.sub = 1'b0; b8.a = 8'h02; b8.b = 8'h02;
        lat = 0;
        while (!b8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t5_first_latency", lat, 8);
        chk("t5_first_result", 32'(b8.result), 32'h02);
        chk("t5_first_cout", 32'(b8.cout), 32'd1);
        @(posedge clk); #1;
        b8.start = 1'b0;
        chk("t5_accept_busy", 32'(b8.busy), 32'd1);
        chk("t5_accept_done", 32'(b8.done), 32'd0);
        lat = 1;
        while (!b8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t5_pulse_spacing", lat, 9);
        chk("t5_second_result", 32'(b8.result), 32'h04);

        // Random 8-bit ops against the model
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(rs, ra, rb, lat, bz);
            model(8, int'(rs), int'(ra), int'(rb), r, c, o);
            chk("rnd_latency", lat, 8);
            chk("rnd_result", 32'(b8.result), r);
            chk("rnd_cout", 32'(b8.cout), c);
            chk("rnd_ovf", 32'(b8.ovf), o);
        end

        // 6: WIDTH=3 exhaustive
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    run3(1'(s), 3'(a), 3'(b), lat);
                    model(3, s, a, b, r, c, o);
                    chk("w3_latency", lat, 3);
                    chk("w3_result", 32'(b3.result), r);
                    chk("w3_cout", 32'(b3.cout), c);
                    chk("w3_ovf", 32'(b3.ovf), o);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
